// File: rtl/piso_shift_tx_pkg.sv
// piso_shift_tx_pkg
// Shared types and helpers for the parallel-in/serial-out transmitter.
//   state_t      : frame FSM states (PARITY is only reachable when
//                  PISO_SHIFT_TX_PARITY_EN is defined)
//   CNT_W        : bit-counter width for the default 8-bit word
//   cnt_width()  : bit-counter width for an arbitrary word length
//   even_parity(): XOR-reduction of a word, zero-extended to MAX_W bits
package piso_shift_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves the XOR unchanged.
    localparam int MAX_W = 64;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    function automatic logic even_parity(input logic [MAX_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// piso_shift_tx_if
// Handshake and serial-link signals of the transmitter.
//   Ce        : bit strobe (source -> tx)
//   Din       : parallel word (source -> tx)
//   Din_valid : Din holds a word (source -> tx)
//   Din_ready : tx accepts Din this cycle (tx -> source)
//   Qout      : serial bit (tx -> link)
//   Qvalid    : Qout carries a frame bit (tx -> link)
//   Done      : one-cycle end-of-frame pulse (tx -> source)
// master = data source / link side, slave = transmitter.
interface piso_shift_tx_if #(
    parameter int WIDTH = 8
);
    logic             Ce;
    logic [WIDTH-1:0] Din;
    logic             Din_valid;
    logic             Din_ready;
    logic             Qout;
    logic             Qvalid;
    logic             Done;

    modport master (
        output Ce, Din, Din_valid,
        input  Din_ready, Qout, Qvalid, Done
    );

    modport slave (
        input  Ce, Din, Din_valid,
        output Din_ready, Qout, Qvalid, Done
    );
endinterface

// File: rtl/piso_shift_tx_bit_counter.sv
// piso_bit_counter
// Ce-gated bit counter for the transmitter.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset (count -> 0)
//   clr_i      : synchronous clear to 0 (highest priority)
//   load_i     : synchronous load of load_val_i
//   load_val_i : value taken on load
//   ce_i       : bit strobe
//   inc_i      : count request; advances only when ce_i is also high
//   tc_o       : count equals TC
module piso_bit_counter #(
    parameter int               CNT_W = 3,
    parameter logic [CNT_W-1:0] TC    = {CNT_W{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             ce_i,
    input  logic             inc_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: clear beats load beats strobed increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (ce_i && inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Terminal-count flag straight off the register.
    always_comb begin
        tc_o = (cnt_q == TC);
    end

endmodule

// File: rtl/piso_shift_tx.sv
// piso_shift_tx
// Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted over a
// valid/ready handshake and sent one bit per Ce-high clock edge on Qout.
// Qout/Qvalid/Done are registered; Din_ready is combinational so that a new
// word can be taken on the edge that consumes the last bit of the current one.
//   CLK  : clock, rising edge
//   RST  : asynchronous active-low reset
//   bus  : piso_shift_tx_if.slave (Ce, Din, Din_valid, Din_ready, Qout,
//          Qvalid, Done)
// Parameters: WIDTH (>=2) word length, MSB_FIRST (1 = Din[WIDTH-1] first).
// Optional: define PISO_SHIFT_TX_PARITY_EN to append an even-parity bit after
// the data bits (frame cost becomes WIDTH+1 strobes).
module piso_shift_tx
    import piso_shift_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic CLK,
    input  logic RST,
    piso_shift_tx_if.slave bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic             qout_q;
    logic             qvalid_q;
    logic             done_q;
`ifdef PISO_SHIFT_TX_PARITY_EN
    logic             par_q;
`endif

    logic             accept_s;
    logic             ready_s;
    logic             frame_end_s;
    logic             cnt_tc_s;
    logic             cnt_clr_s;
    logic             cnt_inc_s;
    logic             first_bit_s;
    logic             next_bit_s;
    logic [WIDTH-1:0] shreg_shift_s;

    // Output-end selection: first bit of a new word and the bit that becomes
    // current after one shift.
    always_comb begin
        if (MSB_FIRST != 0) begin
            first_bit_s   = bus.Din[WIDTH-1];
            next_bit_s    = shreg_q[WIDTH-2];
            shreg_shift_s = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            first_bit_s   = bus.Din[0];
            next_bit_s    = shreg_q[1];
            shreg_shift_s = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    // Handshake and frame-end decode. The frame ends on the strobe that
    // consumes the last bit on the wire (data bit, or parity bit if enabled).
    always_comb begin
`ifdef PISO_SHIFT_TX_PARITY_EN
        frame_end_s = (state_q == PARITY) && bus.Ce;
`else
        frame_end_s = (state_q == SHIFT) && bus.Ce && cnt_tc_s;
`endif
        ready_s   = (state_q == IDLE) || frame_end_s;
        accept_s  = bus.Din_valid && ready_s;
        cnt_clr_s = accept_s || frame_end_s;
        cnt_inc_s = (state_q == SHIFT) && !cnt_tc_s;
    end

    piso_bit_counter #(
        .CNT_W (CW),
        .TC    (LAST)
    ) u_cnt (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .clr_i      (cnt_clr_s),
        .load_i     (1'b0),
        .load_val_i ({CW{1'b0}}),
        .ce_i       (bus.Ce),
        .inc_i      (cnt_inc_s),
        .tc_o       (cnt_tc_s)
    );

    // Frame FSM with shift register and registered serial outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            qout_q   <= 1'b0;
            qvalid_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_q  <= SHIFT;
                        shreg_q  <= bus.Din;
                        qout_q   <= first_bit_s;
                        qvalid_q <= 1'b1;
`ifdef PISO_SHIFT_TX_PARITY_EN
                        par_q    <= even_parity(MAX_W'(bus.Din));
`endif
                    end else begin
                        qout_q   <= 1'b0;
                        qvalid_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bus.Ce && !cnt_tc_s) begin
                        shreg_q <= shreg_shift_s;
                        qout_q  <= next_bit_s;
                    end else if (bus.Ce) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
                        state_q <= PARITY;
                        qout_q  <= par_q;
`else
                        done_q <= 1'b1;
                        if (accept_s) begin
                            shreg_q  <= bus.Din;
                            qout_q   <= first_bit_s;
                            qvalid_q <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                            qout_q   <= 1'b0;
                            qvalid_q <= 1'b0;
                        end
`endif
                    end else begin
                        qout_q <= qout_q;
                    end
                end
`ifdef PISO_SHIFT_TX_PARITY_EN
                PARITY: begin
                    if (bus.Ce) begin
                        done_q <= 1'b1;
                        if (accept_s) begin
                            state_q  <= SHIFT;
                            shreg_q  <= bus.Din;
                            qout_q   <= first_bit_s;
                            qvalid_q <= 1'b1;
                            par_q    <= even_parity(MAX_W'(bus.Din));
                        end else begin
                            state_q  <= IDLE;
                            qout_q   <= 1'b0;
                            qvalid_q <= 1'b0;
                        end
                    end else begin
                        qout_q <= qout_q;
                    end
                end
`endif
                default: begin
                    state_q  <= IDLE;
                    qout_q   <= 1'b0;
                    qvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Din_ready = ready_s;
    assign bus.Qout      = qout_q;
    assign bus.Qvalid    = qvalid_q;
    assign bus.Done      = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx
// Directed bench for piso_shift_tx: one MSB-first and one LSB-first instance
// (WIDTH=8) on a shared clock and reset. Expected bit streams are written out
// from the hand-chosen input words. Builds with or without
// PISO_SHIFT_TX_PARITY_EN.
module tb_piso_shift_tx;

`ifdef PISO_SHIFT_TX_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    piso_shift_tx_if #(.WIDTH(8)) ifm ();
    piso_shift_tx_if #(.WIDTH(8)) ifl ();

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
        .CLK (CLK),
        .RST (RST),
        .bus (ifm)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .CLK (CLK),
        .RST (RST),
        .bus (ifl)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Send one word on the MSB-first instance with a Ce strobe every
    // ce_period cycles; par is the expected parity bit (used only when the
    // parity bit is part of the frame).
    task automatic frame_msb(input logic [7:0] w, input logic par, input int ce_period);
        logic exp_bit;
        ifm.Din       = w;
        ifm.Din_valid = 1'b1;
        ifm.Ce        = 1'b0;
        check("idle_ready", ifm.Din_ready, 1'b1);
        tick();
        ifm.Din_valid = 1'b0;
        check("first_qvalid", ifm.Qvalid, 1'b1);
        for (int i = 0; i < FRAME; i++) begin
            exp_bit = (i < 8) ? w[7-i] : par;
            for (int j = 0; j < ce_period; j++) begin
                ifm.Ce = (j == ce_period - 1);
                #1;
                check("bit", ifm.Qout, exp_bit);
                check("bit_qvalid", ifm.Qvalid, 1'b1);
                check("bit_done", ifm.Done, 1'b0);
                check("bit_ready", ifm.Din_ready, ((i == FRAME - 1) && ifm.Ce) ? 1'b1 : 1'b0);
                tick();
            end
        end
        ifm.Ce = 1'b0;
        check("done_pulse", ifm.Done, 1'b1);
        check("end_qvalid", ifm.Qvalid, 1'b0);
        check("end_qout", ifm.Qout, 1'b0);
        tick();
        check("done_single", ifm.Done, 1'b0);
    endtask

    initial begin
        logic exp_bit;
        int   b;
        n_checks      = 0;
        n_errors      = 0;
        RST           = 1'b0;
        ifm.Ce        = 1'b0;
        ifm.Din       = 8'h00;
        ifm.Din_valid = 1'b0;
        ifl.Ce        = 1'b0;
        ifl.Din       = 8'h00;
        ifl.Din_valid = 1'b0;

        // Reset state
        #12;
        check("rst_qout", ifm.Qout, 1'b0);
        check("rst_qvalid", ifm.Qvalid, 1'b0);
        check("rst_done", ifm.Done, 1'b0);
        check("rst_ready", ifm.Din_ready, 1'b1);
        tick();
        RST = 1'b1;
        tick();

        // Basic frame 0xA5, Ce every cycle: 1,0,1,0,0,1,0,1
        frame_msb(8'hA5, 1'b0, 1);

        // Sparse Ce: 0x3C, strobe every 3rd cycle
        frame_msb(8'h3C, 1'b0, 3);

        // Parity words (parity bit only on the wire with the feature on)
        frame_msb(8'h07, 1'b1, 1);
        frame_msb(8'h03, 1'b0, 1);

        // Reset mid-frame after 3 bits of 0xA5
        ifm.Din       = 8'hA5;
        ifm.Din_valid = 1'b1;
        tick();
        ifm.Din_valid = 1'b0;
        ifm.Ce        = 1'b1;
        tick();
        tick();
        tick();
        check("pre_rst_bit3", ifm.Qout, 1'b0);
        check("pre_rst_qvalid", ifm.Qvalid, 1'b1);
        #1;
        RST = 1'b0;
        #1;
        check("midrst_qout", ifm.Qout, 1'b0);
        check("midrst_qvalid", ifm.Qvalid, 1'b0);
        check("midrst_done", ifm.Done, 1'b0);
        ifm.Ce = 1'b0;
        tick();
        RST = 1'b1;
        #1;
        check("postrst_ready", ifm.Din_ready, 1'b1);
        tick();
        check("postrst_done", ifm.Done, 1'b0);
        check("postrst_qvalid", ifm.Qvalid, 1'b0);

        // LSB-first 0x01 with Din_valid held high (Din=0xFF) mid-frame
        ifl.Din       = 8'h01;
        ifl.Din_valid = 1'b1;
        ifl.Ce        = 1'b1;
        tick();
        ifl.Din = 8'hFF;
        for (int i = 0; i < FRAME; i++) begin
            // parity of 0x01 is 1
            exp_bit = (i < 8) ? ((i == 0) ? 1'b1 : 1'b0) : 1'b1;
            if (i == FRAME - 1) begin
                ifl.Din_valid = 1'b0;
            end else begin
                #1;
                check("lsb_stall_ready", ifl.Din_ready, 1'b0);
            end
            check("lsb_bit", ifl.Qout, exp_bit);
            check("lsb_qvalid", ifl.Qvalid, 1'b1);
            tick();
        end
        ifl.Ce = 1'b0;
        check("lsb_done", ifl.Done, 1'b1);
        check("lsb_end_qvalid", ifl.Qvalid, 1'b0);
        tick();

        // Back-to-back 0xFF then 0x00, Din_valid high, Ce=1
        ifm.Din       = 8'hFF;
        ifm.Din_valid = 1'b1;
        ifm.Ce        = 1'b1;
        tick();
        ifm.Din = 8'h00;
        for (int c = 0; c < 2 * FRAME; c++) begin
            b       = c % FRAME;
            exp_bit = (b < 8) ? ((c < FRAME) ? 1'b1 : 1'b0) : 1'b0;
            #1;
            check("b2b_bit", ifm.Qout, exp_bit);
            check("b2b_qvalid", ifm.Qvalid, 1'b1);
            check("b2b_done", ifm.Done, (c == FRAME) ? 1'b1 : 1'b0);
            check("b2b_ready", ifm.Din_ready,
                  ((c == FRAME - 1) || (c == 2 * FRAME - 1)) ? 1'b1 : 1'b0);
            tick();
            if (c == FRAME - 1) begin
                ifm.Din_valid = 1'b0;
            end
        end
        ifm.Ce = 1'b0;
        check("b2b_done2", ifm.Done, 1'b1);
        check("b2b_end_qvalid", ifm.Qvalid, 1'b0);
        tick();
        check("b2b_done_single", ifm.Done, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
